// File: rtl/uart_pkg.sv
// uart_pkg: definitions shared by the UART transmit arbiter and its picker.
//   - arb_state_e : arbiter FSM encoding (IDLE=0, START=1, WAIT=2, RELEASE=3)
//   - gid_width() : width of a requester index, never less than 1 bit
//   - DefaultDataW: default byte width, matching uart_tx data_in
package uart_pkg;

    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StStart   = 2'd1,
        StWait    = 2'd2,
        StRelease = 2'd3
    } arb_state_e;

    localparam int unsigned DefaultDataW = 8;

    function automatic int unsigned gid_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_picker.sv
// rr_picker: combinational round-robin winner selection.
// Ports:
//   req_valid [N_REQ]  in  - pending requests
//   last      [GID_W]  in  - index granted most recently
//   any_valid          out - at least one request pending
//   winner    [GID_W]  out - first valid index searching from last+1 (mod N_REQ)
module rr_picker #(
    parameter int unsigned N_REQ = 4,
    parameter int unsigned GID_W = 2
) (
    input  logic [N_REQ-1:0] req_valid,
    input  logic [GID_W-1:0] last,
    output logic             any_valid,
    output logic [GID_W-1:0] winner
);

    always_comb begin
        any_valid = |req_valid;
        winner    = '0;
        // Walk from furthest to nearest so the nearest valid index after
        // last is the one left in winner.
        for (int i = N_REQ; i >= 1; i--) begin
            int unsigned idx;
            idx = (int'(last) + i) % N_REQ;
            if (req_valid[idx]) begin
                winner = GID_W'(idx);
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: shares one uart_tx between N_REQ byte producers.
// A byte is captured from the round-robin winner, launched with a one-cycle
// tx_start, and the grant is held until uart_tx signals tx_done (pulse or level).
// Ports:
//   clk, rst              - clock, asynchronous active-high reset
//   req_valid/req_data    - requester handshake; req_data flattened per requester
//   req_ack               - one-cycle one-hot capture acknowledge
//   tx_start/tx_data      - to uart_tx tx_start/data_in
//   tx_done               - from uart_tx
//   busy                  - high in START/WAIT/RELEASE
//   grant_id              - current or last granted requester
//   timeout_err           - one-cycle pulse on WAIT timeout
// Optional feature macro: UART_TX_ARB_TIMEOUT_EN enables the WAIT timeout
// counter; without it WAIT is unbounded and timeout_err is tied low.
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int unsigned N_REQ          = 4,
    parameter int unsigned DATA_W         = DefaultDataW,
    parameter int unsigned TIMEOUT_CYCLES = 65535,
    localparam int unsigned GID_W         = gid_width(N_REQ)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [N_REQ-1:0]        req_valid,
    input  logic [N_REQ*DATA_W-1:0] req_data,
    output logic [N_REQ-1:0]        req_ack,
    output logic                    tx_start,
    output logic [DATA_W-1:0]       tx_data,
    input  logic                    tx_done,
    output logic                    busy,
    output logic [GID_W-1:0]        grant_id,
    output logic                    timeout_err
);

    arb_state_e         state_q, state_d;
    logic [GID_W-1:0]   last_q, last_d;
    logic [GID_W-1:0]   grant_id_q, grant_id_d;
    logic [DATA_W-1:0]  tx_data_q, tx_data_d;
    logic [N_REQ-1:0]   req_ack_q, req_ack_d;
    logic               tx_start_q, tx_start_d;
    logic               busy_q, busy_d;
    logic               timeout_err_d;

    logic               any_valid;
    logic [GID_W-1:0]   winner;

    rr_picker #(
        .N_REQ (N_REQ),
        .GID_W (GID_W)
    ) u_picker (
        .req_valid (req_valid),
        .last      (last_q),
        .any_valid (any_valid),
        .winner    (winner)
    );

`ifdef UART_TX_ARB_TIMEOUT_EN
    localparam int unsigned CNT_W = (TIMEOUT_CYCLES < 1) ? 1 : $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] cnt_inc;
    logic             timeout_err_q;
    logic             timeout_hit;

    assign cnt_inc     = cnt_q + 1'b1;
    assign timeout_hit = (cnt_inc == CNT_W'(TIMEOUT_CYCLES));

    // Counts only while waiting; START always leaves it at zero for WAIT entry.
    always_comb begin
        cnt_d = '0;
        if (state_q == StWait) begin
            cnt_d = cnt_inc;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q         <= '0;
            timeout_err_q <= 1'b0;
        end else begin
            cnt_q         <= cnt_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    assign timeout_err = timeout_err_q;
`else
    logic timeout_hit;

    assign timeout_hit = 1'b0;
    assign timeout_err = 1'b0;
`endif

    always_comb begin
        state_d       = state_q;
        last_d        = last_q;
        grant_id_d    = grant_id_q;
        tx_data_d     = tx_data_q;
        req_ack_d     = '0;
        timeout_err_d = 1'b0;

        case (state_q)
            StIdle: begin
                if (any_valid) begin
                    tx_data_d         = req_data[int'(winner)*DATA_W +: DATA_W];
                    grant_id_d        = winner;
                    last_d            = winner;
                    req_ack_d[winner] = 1'b1;
                    state_d           = StStart;
                end
            end
            StStart: begin
                state_d = StWait;
            end
            StWait: begin
                if (tx_done) begin
                    state_d = StRelease;
                end else if (timeout_hit) begin
                    // Grant pointer was already advanced at capture, so the
                    // next requester still gets its turn after an abort.
                    timeout_err_d = 1'b1;
                    state_d       = StRelease;
                end
            end
            StRelease: begin
                // Wait for tx_done to drop so a level-style done cannot
                // retrigger a frame.
                if (!tx_done) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // Outputs are registered from the next state so they align with it.
        tx_start_d = (state_d == StStart);
        busy_d     = (state_d != StIdle);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StIdle;
            last_q     <= GID_W'(N_REQ - 1);
            grant_id_q <= '0;
            tx_data_q  <= '0;
            req_ack_q  <= '0;
            tx_start_q <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            last_q     <= last_d;
            grant_id_q <= grant_id_d;
            tx_data_q  <= tx_data_d;
            req_ack_q  <= req_ack_d;
            tx_start_q <= tx_start_d;
            busy_q     <= busy_d;
        end
    end

    assign req_ack  = req_ack_q;
    assign tx_start = tx_start_q;
    assign tx_data  = tx_data_q;
    assign busy     = busy_q;
    assign grant_id = grant_id_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed self-checking bench for uart_tx_arbiter (N_REQ=4, DATA_W=8,
// TIMEOUT_CYCLES=100). uart_tx is modelled by driving tx_done directly.
// Outputs are sampled and inputs driven at the falling clock edge.
module tb_uart_tx_arbiter;

    localparam int unsigned N = 4;
    localparam int unsigned W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic [N-1:0] req_valid;
    logic [N*W-1:0] req_data;
    logic [N-1:0] req_ack;
    logic         tx_start;
    logic [W-1:0] tx_data;
    logic         tx_done;
    logic         busy;
    logic [1:0]   grant_id;
    logic         timeout_err;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    uart_tx_arbiter #(
        .N_REQ          (N),
        .DATA_W         (W),
        .TIMEOUT_CYCLES (100)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_data    (req_data),
        .req_ack     (req_ack),
        .tx_start    (tx_start),
        .tx_data     (tx_data),
        .tx_done     (tx_done),
        .busy        (busy),
        .grant_id    (grant_id),
        .timeout_err (timeout_err)
    );

    task automatic do_reset();
        @(negedge clk);
        rst       = 1'b1;
        req_valid = '0;
        tx_done   = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    // From the START cycle: one-cycle tx_done pulse in WAIT, return in IDLE.
    task automatic run_tail();
        @(negedge clk);
        tx_done = 1'b1;
        @(negedge clk);
        tx_done = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({busy, tx_start, req_ack, grant_id, timeout_err} !== 9'b0 || tx_data !== 8'h00) begin
            errors++;
            $display("FAIL reset_values got busy=%b start=%b ack=%b gid=%0d terr=%b data=%h exp all 0",
                     busy, tx_start, req_ack, grant_id, timeout_err, tx_data);
        end
    endtask

    task automatic test_first_grant();
        req_data[7:0] = 8'h55;
        req_valid     = 4'b0001;
        @(negedge clk);
        checks++;
        if (req_ack !== 4'b0001 || tx_start !== 1'b1 || tx_data !== 8'h55 ||
            grant_id !== 2'd0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL first_grant got ack=%b start=%b data=%h gid=%0d busy=%b exp 0001 1 55 0 1",
                     req_ack, tx_start, tx_data, grant_id, busy);
        end
        req_valid = 4'b0000;
        @(negedge clk);
        checks++;
        if (req_ack !== 4'b0000 || tx_start !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL first_wait got ack=%b start=%b busy=%b exp 0000 0 1",
                     req_ack, tx_start, busy);
        end
        tx_done = 1'b1;
        @(negedge clk);
        tx_done = 1'b0;
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL first_release busy got %b exp 1", busy);
        end
        @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL first_idle busy got %b exp 0", busy);
        end
    endtask

    task automatic test_round_robin();
        int exp_id[5] = '{0, 1, 2, 3, 0};
        do_reset();
        for (int i = 0; i < 4; i++) req_data[i*W +: W] = 8'hA0 + 8'(i);
        req_valid = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            logic [3:0] exp_ack;
            exp_ack = 4'b0001 << exp_id[k];
            // Each iteration enters here 3 cycles after the previous tx_done.
            @(negedge clk);
            checks++;
            if (req_ack !== exp_ack || grant_id !== 2'(exp_id[k]) || tx_start !== 1'b1 ||
                tx_data !== 8'hA0 + 8'(exp_id[k])) begin
                errors++;
                $display("FAIL rr_grant%0d got ack=%b gid=%0d start=%b data=%h exp %b %0d 1 %h",
                         k, req_ack, grant_id, tx_start, tx_data, exp_ack, exp_id[k],
                         8'hA0 + 8'(exp_id[k]));
            end
            @(negedge clk);
            checks++;
            if (tx_start !== 1'b0 || busy !== 1'b1 || tx_data !== 8'hA0 + 8'(exp_id[k])) begin
                errors++;
                $display("FAIL rr_wait%0d got start=%b busy=%b data=%h exp 0 1 %h",
                         k, tx_start, busy, tx_data, 8'hA0 + 8'(exp_id[k]));
            end
            tx_done = 1'b1;
            @(negedge clk);
            tx_done = 1'b0;
            @(negedge clk);
            checks++;
            if (busy !== 1'b0 || tx_start !== 1'b0) begin
                errors++;
                $display("FAIL rr_idle%0d got busy=%b start=%b exp 0 0", k, busy, tx_start);
            end
        end
        req_valid = 4'b0000;
    endtask

    task automatic test_skip_idle();
        req_valid = 4'b0010;
        @(negedge clk);
        checks++;
        if (grant_id !== 2'd1 || req_ack !== 4'b0010) begin
            errors++;
            $display("FAIL skip_g1 got gid=%0d ack=%b exp 1 0010", grant_id, req_ack);
        end
        req_valid = 4'b1010;
        run_tail();
        @(negedge clk);
        checks++;
        if (grant_id !== 2'd3 || req_ack !== 4'b1000 || tx_data !== 8'hA3) begin
            errors++;
            $display("FAIL skip_g3 got gid=%0d ack=%b data=%h exp 3 1000 a3",
                     grant_id, req_ack, tx_data);
        end
        run_tail();
        @(negedge clk);
        checks++;
        if (grant_id !== 2'd1 || req_ack !== 4'b0010 || tx_data !== 8'hA1) begin
            errors++;
            $display("FAIL skip_g1b got gid=%0d ack=%b data=%h exp 1 0010 a1",
                     grant_id, req_ack, tx_data);
        end
        req_valid = 4'b0000;
        run_tail();
    endtask

    task automatic test_level_done();
        int bad = 0;
        req_valid = 4'b0100;
        @(negedge clk);
        checks++;
        if (grant_id !== 2'd2 || tx_start !== 1'b1) begin
            errors++;
            $display("FAIL level_grant got gid=%0d start=%b exp 2 1", grant_id, tx_start);
        end
        @(negedge clk);
        tx_done = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (tx_start !== 1'b0 || busy !== 1'b1) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL level_hold got %0d bad cycles exp 0 (start low, busy high)", bad);
        end
        tx_done = 1'b0;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL level_idle busy got %b exp 0", busy);
        end
        @(negedge clk);
        checks++;
        if (tx_start !== 1'b1 || grant_id !== 2'd2) begin
            errors++;
            $display("FAIL level_next got start=%b gid=%0d exp 1 2", tx_start, grant_id);
        end
        req_valid = 4'b0000;
        run_tail();
    endtask

    task automatic test_reset_mid_frame();
        req_valid = 4'b0100;
        @(negedge clk);
        req_valid = 4'b1111;
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({busy, tx_start, req_ack, grant_id} !== 8'b0 || tx_data !== 8'h00) begin
            errors++;
            $display("FAIL mid_reset got busy=%b start=%b ack=%b gid=%0d data=%h exp all 0",
                     busy, tx_start, req_ack, grant_id, tx_data);
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (grant_id !== 2'd0 || req_ack !== 4'b0001 || tx_data !== 8'hA0) begin
            errors++;
            $display("FAIL mid_regrant got gid=%0d ack=%b data=%h exp 0 0001 a0",
                     grant_id, req_ack, tx_data);
        end
        req_valid = 4'b0000;
        run_tail();
    endtask

    task automatic test_timeout();
        int bad = 0;
        do_reset();
        req_valid = 4'b0011;
        @(negedge clk);
        checks++;
        if (grant_id !== 2'd0 || tx_start !== 1'b1) begin
            errors++;
            $display("FAIL to_grant0 got gid=%0d start=%b exp 0 1", grant_id, tx_start);
        end
        req_valid = 4'b0010;
        @(negedge clk);  // first WAIT cycle
`ifdef UART_TX_ARB_TIMEOUT_EN
        for (int j = 1; j < 100; j++) begin
            @(negedge clk);
            if (timeout_err !== 1'b0 || busy !== 1'b1 || tx_start !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL to_early got %0d bad cycles exp 0", bad);
        end
        @(negedge clk);
        checks++;
        if (timeout_err !== 1'b1 || busy !== 1'b1) begin
            errors++;
            $display("FAIL to_pulse got terr=%b busy=%b exp 1 1", timeout_err, busy);
        end
        @(negedge clk);
        checks++;
        if (timeout_err !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL to_after got terr=%b busy=%b exp 0 0", timeout_err, busy);
        end
        @(negedge clk);
        checks++;
        if (tx_start !== 1'b1 || grant_id !== 2'd1) begin
            errors++;
            $display("FAIL to_next got start=%b gid=%0d exp 1 1", tx_start, grant_id);
        end
`else
        for (int j = 0; j < 130; j++) begin
            @(negedge clk);
            if (timeout_err !== 1'b0 || busy !== 1'b1 || tx_start !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL no_timeout got %0d bad cycles exp 0 (stuck in WAIT)", bad);
        end
`endif
        do_reset();
    endtask

    initial begin
        rst       = 1'b1;
        req_valid = '0;
        req_data  = '0;
        tx_done   = 1'b0;
        test_reset();
        test_first_grant();
        test_round_robin();
        test_skip_idle();
        test_level_done();
        test_reset_mid_frame();
        test_timeout();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout exp completion");
        $fatal(1, "watchdog");
    end

endmodule
